cp0_intc: RTL and testbench

- Coprocessor-0 interrupt/exception responder for the pipelined MIPS core.
- It consumes device interrupt lines (timer IntReq on HWInt[2], others above it) and decides when the CPU is interrupted.
- It holds SR/Cause/EPC/PRId, which the core reads with mfc0 and writes with mtc0 over an addr/Din/we/Dout register port.
- It sits beside the M stage; the core flushes and redirects to the handler when IntReq is high.

---
 rtl/cp0_pkg.sv | 32 +++
 rtl/cp0_count_compare.sv | 35 +++
 rtl/cp0_intc.sv | 109 ++++++++++
 tb/tb_cp0_intc.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, exception codes and register field positions
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD_BIT = 31;

    // Word-aligned restart PC: a delay-slot fault restarts at the branch.
    function automatic logic [29:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] p;
        p = bd ? pc - 32'd4 : pc;
        return p[31:2];
    endfunction

endpackage

// File: rtl/cp0_count_compare.sv
// rtl/cp0_count_compare.sv - Count/Compare timer with sticky TI flag, built only with CP0_COUNT_EN
`ifdef CP0_COUNT_EN
module cp0_count_compare
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr,
    input  logic [31:0] Din,
    input  logic        we,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            if (we && addr == REG_COUNT) count <= Din;
            else                         count <= count + 32'd1;
            // Writing Compare acknowledges the timer, even on a matching cycle.
            if (we && addr == REG_COMPARE) begin
                compare <= Din;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti      <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/cp0_intc.sv
// rtl/cp0_intc.sv - CP0 interrupt/exception responder (SR/Cause/EPC/PRId); CP0_COUNT_EN adds Count/Compare
module cp0_intc
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID    = 32'h0000_4D50,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr,
    input  logic [31:0] Din,
    input  logic        we,
    output logic [31:0] Dout,
    input  logic [5:0]  HWInt,
    input  logic        exc_in,
    input  logic [4:0]  exc_code,
    input  logic        bd_in,
    input  logic [31:0] pc_in,
    input  logic        eret,
    output logic        IntReq,
    output logic [31:0] epc,
    output logic [31:0] vector
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exccode;
    logic [29:0] epc_q;
    logic        int_pend;
    logic        take;
    logic        sr_we;
    logic        epc_we;
    logic        ti;

`ifdef CP0_COUNT_EN
    logic [31:0] count;
    logic [31:0] compare;

    cp0_count_compare u_count_compare (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .Din     (Din),
        .we      (we),
        .count   (count),
        .compare (compare),
        .ti      (ti)
    );
`else
    assign ti = 1'b0;
`endif

    assign sr_we    = we && (addr == REG_SR);
    assign epc_we   = we && (addr == REG_EPC);
    assign int_pend = (|(ip & im)) & ie & ~exl;
    assign take     = int_pend | (exc_in & ~exl);
    // Gated by reset so the request drops the moment reset asserts.
    assign IntReq   = take & reset;
    assign epc      = {epc_q, 2'b00};
    assign vector   = HANDLER;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im      <= 6'd0;
            exl     <= 1'b0;
            ie      <= 1'b0;
            bd      <= 1'b0;
            ip      <= 6'd0;
            exccode <= 5'd0;
            epc_q   <= 30'd0;
        end else begin
            ip <= {HWInt[5] | ti, HWInt[4:0]};
            if (sr_we) begin
                im <= Din[SR_IM_HI:SR_IM_LO];
                ie <= Din[SR_IE_BIT];
            end
            // Entry outranks eret, which outranks an mtc0 to EXL or EPC.
            if (take) begin
                exl     <= 1'b1;
                bd      <= bd_in;
                exccode <= int_pend ? EXC_INT : exc_code;
                epc_q   <= epc_of(pc_in, bd_in);
            end else begin
                if (eret)       exl <= 1'b0;
                else if (sr_we) exl <= Din[SR_EXL_BIT];
                if (epc_we)     epc_q <= Din[31:2];
            end
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (addr)
            REG_SR:    Dout = {16'd0, im, 8'd0, exl, ie};
            REG_CAUSE: Dout = {bd, 15'd0, ip, 3'd0, exccode, 2'b00};
            REG_EPC:   Dout = {epc_q, 2'b00};
            REG_PRID:  Dout = PRID;
`ifdef CP0_COUNT_EN
            REG_COUNT:   Dout = count;
            REG_COMPARE: Dout = compare;
`endif
            default:   Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intc.sv
// tb/tb_cp0_intc.sv - scoreboard bench for cp0_intc (default build; CP0_COUNT_EN adds timer checks)
module tb_cp0_intc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] Din = 32'd0;
    logic        we = 1'b0;
    logic [31:0] Dout;
    logic [5:0]  HWInt = 6'd0;
    logic        exc_in = 1'b1;
    logic [4:0]  exc_code = 5'd0;
    logic        bd_in = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic        eret = 1'b0;
    logic        IntReq;
    logic [31:0] epc;
    logic [31:0] vector;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

`ifdef CP0_COUNT_EN
    localparam logic [31:0] CMASK = 32'hFFFF_7FFF;
`else
    localparam logic [31:0] CMASK = 32'hFFFF_FFFF;
`endif

    cp0_intc #(.PRID(32'h0000_4D50), .HANDLER(32'h0000_4180)) dut (
        .clk(clk), .reset(reset), .addr(addr), .Din(Din), .we(we), .Dout(Dout),
        .HWInt(HWInt), .exc_in(exc_in), .exc_code(exc_code), .bd_in(bd_in),
        .pc_in(pc_in), .eret(eret), .IntReq(IntReq), .epc(epc), .vector(vector)
    );

    always #50 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        addr = a; Din = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        addr = a;
        #1;
    endtask

    task automatic test_reset();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'h0000_4180);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, IntReq} !== exp_v) begin n_err++; $display("FAIL rst_intreq: got %h want %h", IntReq, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (epc !== exp_v) begin n_err++; $display("FAIL rst_epc: got %h want %h", epc, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (vector !== exp_v) begin n_err++; $display("FAIL rst_vector: got %h want %h", vector, exp_v); end
        rd(12); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL rst_sr: got %h want %h", Dout, exp_v); end
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL rst_cause: got %h want %h", Dout, exp_v); end
        rd(14); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL rst_epcreg: got %h want %h", Dout, exp_v); end
        exc_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_interrupt();
        mtc0(12, 32'h0000_0401);
        exp_q.push_back(32'h0000_0401);
        rd(12); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL int_sr_write: got %h want %h", Dout, exp_v); end
        HWInt = 6'b000001; pc_in = 32'h0000_3010;
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        #1; exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, IntReq} !== exp_v) begin n_err++; $display("FAIL int_latency0: got %h want %h", IntReq, exp_v); end
        step();
        exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, IntReq} !== exp_v) begin n_err++; $display("FAIL int_latency1: got %h want %h", IntReq, exp_v); end
        exp_q.push_back(32'd0); exp_q.push_back(32'h0000_0403); exp_q.push_back(32'h0000_0400);
        exp_q.push_back(32'h0000_3010); exp_q.push_back(32'h0000_3010);
        step();
        exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, IntReq} !== exp_v) begin n_err++; $display("FAIL int_masked_by_exl: got %h want %h", IntReq, exp_v); end
        rd(12); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL int_sr_exl: got %h want %h", Dout, exp_v); end
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ((Dout & CMASK) !== exp_v) begin n_err++; $display("FAIL int_cause: got %h want %h", Dout, exp_v); end
        rd(14); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL int_epcreg: got %h want %h", Dout, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (epc !== exp_v) begin n_err++; $display("FAIL int_epc_out: got %h want %h", epc, exp_v); end
    endtask

    task automatic test_eret();
        eret = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'h0000_0401); exp_q.push_back(32'd1);
        #1; exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, IntReq} !== exp_v) begin n_err++; $display("FAIL eret_during: got %h want %h", IntReq, exp_v); end
        step();
        eret = 1'b0;
        rd(12); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL eret_sr: got %h want %h", Dout, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, IntReq} !== exp_v) begin n_err++; $display("FAIL eret_repend: got %h want %h", IntReq, exp_v); end
        pc_in = 32'h0000_3014;
        exp_q.push_back(32'h0000_3014);
        step();
        HWInt = 6'd0;
        rd(14); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL eret_reentry_epc: got %h want %h", Dout, exp_v); end
        step();
        mtc0(12, 32'd0);
    endtask

    task automatic test_exception();
        exc_in = 1'b1; exc_code = 5'd12; bd_in = 1'b1; pc_in = 32'h0000_3024;
        exp_q.push_back(32'd1); exp_q.push_back(32'h0000_3020);
        exp_q.push_back(32'h8000_0030); exp_q.push_back(32'h0000_0002);
        #1; exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, IntReq} !== exp_v) begin n_err++; $display("FAIL exc_intreq: got %h want %h", IntReq, exp_v); end
        step();
        exc_in = 1'b0; bd_in = 1'b0;
        rd(14); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL exc_bd_epc: got %h want %h", Dout, exp_v); end
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ((Dout & CMASK) !== exp_v) begin n_err++; $display("FAIL exc_cause: got %h want %h", Dout, exp_v); end
        rd(12); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL exc_sr: got %h want %h", Dout, exp_v); end
        exc_in = 1'b1; exc_code = 5'd4; pc_in = 32'h0000_5000;
        exp_q.push_back(32'd0); exp_q.push_back(32'h0000_3020); exp_q.push_back(32'h8000_0030);
        #1; exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, IntReq} !== exp_v) begin n_err++; $display("FAIL nested_intreq: got %h want %h", IntReq, exp_v); end
        step();
        exc_in = 1'b0;
        rd(14); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL nested_epc: got %h want %h", Dout, exp_v); end
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ((Dout & CMASK) !== exp_v) begin n_err++; $display("FAIL nested_cause: got %h want %h", Dout, exp_v); end
        eret = 1'b1;
        exp_q.push_back(32'd0);
        step();
        eret = 1'b0;
        rd(12); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL exc_eret_sr: got %h want %h", Dout, exp_v); end
    endtask

    task automatic test_priority();
        mtc0(12, 32'h0000_0401);
        HWInt = 6'b000001;
        step();
        exc_in = 1'b1; exc_code = 5'd10; bd_in = 1'b0; pc_in = 32'h0000_3100;
        exp_q.push_back(32'd1); exp_q.push_back(32'h0000_0400); exp_q.push_back(32'h0000_3100);
        #1; exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, IntReq} !== exp_v) begin n_err++; $display("FAIL prio_intreq: got %h want %h", IntReq, exp_v); end
        step();
        exc_in = 1'b0; HWInt = 6'd0;
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ((Dout & CMASK) !== exp_v) begin n_err++; $display("FAIL prio_int_wins: got %h want %h", Dout, exp_v); end
        rd(14); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL prio_epc: got %h want %h", Dout, exp_v); end
        eret = 1'b1; addr = 5'd12; Din = 32'h0000_0003; we = 1'b1;
        exp_q.push_back(32'h0000_0001);
        step();
        eret = 1'b0; we = 1'b0;
        rd(12); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL eret_over_mtc0: got %h want %h", Dout, exp_v); end
        mtc0(12, 32'd0);
    endtask

    task automatic test_entry_collisions();
        exc_in = 1'b1; exc_code = 5'd5; pc_in = 32'h0000_3200;
        addr = 5'd12; Din = 32'h0000_0800; we = 1'b1;
        exp_q.push_back(32'h0000_0802); exp_q.push_back(32'h0000_0014);
        step();
        exc_in = 1'b0; we = 1'b0;
        rd(12); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL entry_mtc0_sr: got %h want %h", Dout, exp_v); end
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ((Dout & CMASK) !== exp_v) begin n_err++; $display("FAIL entry_mtc0_cause: got %h want %h", Dout, exp_v); end
        eret = 1'b1;
        step();
        eret = 1'b0;
        exc_in = 1'b1; exc_code = 5'd4; pc_in = 32'h0000_3300; eret = 1'b1;
        addr = 5'd14; Din = 32'h0000_1234; we = 1'b1;
        exp_q.push_back(32'h0000_0802); exp_q.push_back(32'h0000_3300); exp_q.push_back(32'h0000_0010);
        step();
        exc_in = 1'b0; eret = 1'b0; we = 1'b0;
        rd(12); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL entry_eret_sr: got %h want %h", Dout, exp_v); end
        rd(14); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL entry_mtc0_epc: got %h want %h", Dout, exp_v); end
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ((Dout & CMASK) !== exp_v) begin n_err++; $display("FAIL entry_eret_cause: got %h want %h", Dout, exp_v); end
        eret = 1'b1;
        step();
        eret = 1'b0;
        mtc0(12, 32'd0);
    endtask

    task automatic test_regs();
        mtc0(13, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0010); exp_q.push_back(32'h0000_4D50); exp_q.push_back(32'd0);
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ((Dout & CMASK) !== exp_v) begin n_err++; $display("FAIL cause_readonly: got %h want %h", Dout, exp_v); end
        rd(15); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL prid: got %h want %h", Dout, exp_v); end
        rd(7); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL unmapped: got %h want %h", Dout, exp_v); end
        mtc0(14, 32'h0000_3003);
        exp_q.push_back(32'h0000_3000);
        rd(14); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL epc_align: got %h want %h", Dout, exp_v); end
        addr = 5'd14; Din = 32'h0000_4440; we = 1'b1;
        exp_q.push_back(32'h0000_3000); exp_q.push_back(32'h0000_4440);
        #1; exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL no_bypass: got %h want %h", Dout, exp_v); end
        step();
        we = 1'b0;
        rd(14); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL epc_after_write: got %h want %h", Dout, exp_v); end
    endtask

    task automatic test_count();
`ifdef CP0_COUNT_EN
        mtc0(9, 32'd0);
        mtc0(11, 32'd5);
        exp_q.push_back(32'd5); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        repeat (4) step();
        rd(9); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL count_value: got %h want %h", Dout, exp_v); end
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, Dout[15]} !== exp_v) begin n_err++; $display("FAIL ip7_before: got %h want %h", Dout[15], exp_v); end
        step();
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, Dout[15]} !== exp_v) begin n_err++; $display("FAIL ip7_ti_edge: got %h want %h", Dout[15], exp_v); end
        step();
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, Dout[15]} !== exp_v) begin n_err++; $display("FAIL ip7_set: got %h want %h", Dout[15], exp_v); end
        mtc0(11, 32'd100);
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, Dout[15]} !== exp_v) begin n_err++; $display("FAIL ip7_clear_lag: got %h want %h", Dout[15], exp_v); end
        step();
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, Dout[15]} !== exp_v) begin n_err++; $display("FAIL ip7_cleared: got %h want %h", Dout[15], exp_v); end
`else
        mtc0(9, 32'h0000_0055);
        mtc0(11, 32'h0000_0066);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        rd(9); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL count_absent: got %h want %h", Dout, exp_v); end
        rd(11); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL compare_absent: got %h want %h", Dout, exp_v); end
        step();
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, Dout[15]} !== exp_v) begin n_err++; $display("FAIL ip7_absent: got %h want %h", Dout[15], exp_v); end
`endif
    endtask

    task automatic test_reset_mid();
        exc_in = 1'b1; exc_code = 5'd12; bd_in = 1'b0; pc_in = 32'h0000_3400;
        exp_q.push_back(32'h0000_3400);
        step();
        exc_in = 1'b0;
        rd(14); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL mid_pre_epc: got %h want %h", Dout, exp_v); end
        #10;
        reset = 1'b0; exc_in = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1; exp_v = exp_q.pop_front(); n_cmp++;
        if ({31'd0, IntReq} !== exp_v) begin n_err++; $display("FAIL mid_intreq: got %h want %h", IntReq, exp_v); end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (epc !== exp_v) begin n_err++; $display("FAIL mid_epc_out: got %h want %h", epc, exp_v); end
        rd(12); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL mid_sr: got %h want %h", Dout, exp_v); end
        rd(13); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL mid_cause: got %h want %h", Dout, exp_v); end
        rd(14); exp_v = exp_q.pop_front(); n_cmp++;
        if (Dout !== exp_v) begin n_err++; $display("FAIL mid_epcreg: got %h want %h", Dout, exp_v); end
        exc_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_eret();
        test_exception();
        test_priority();
        test_entry_collisions();
        test_regs();
        test_count();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
